// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - Pipeline stall/flush/halt controller; PIPE_PERF_EN adds cycle/stall/flush counters
module pipe_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        stallReq,
    input  logic        flushReq,
    input  logic        memBusy,
    input  logic        haltReq,
    output logic        pcEn,
    output logic        ifidEn,
    output logic        idexEn,
    output logic        exmemEn,
    output logic        memwbEn,
    output logic        ifidFlush,
    output logic        idexBubble,
    output logic        halted,
    output logic [1:0]  state
`ifdef PIPE_PERF_EN
    ,
    output logic [15:0] cycCnt,
    output logic [15:0] stallCnt,
    output logic [15:0] flushCnt
`endif
);

    typedef enum logic [1:0] {
        RUN     = 2'b00,
        MEMWAIT = 2'b01,
        HALT    = 2'b10,
        RSVD    = 2'b11
    } state_t;

    state_t curState, nextState;
    logic   pendFlush, pendFlushNext;

    assign state = curState;

    always_ff @(posedge clk) begin
        curState  <= nextState;
        pendFlush <= pendFlushNext;
    end

    always_comb begin
        nextState     = curState;
        pendFlushNext = pendFlush;
        pcEn          = 1'b0;
        ifidEn        = 1'b0;
        idexEn        = 1'b0;
        exmemEn       = 1'b0;
        memwbEn       = 1'b0;
        ifidFlush     = 1'b0;
        idexBubble    = 1'b0;
        halted        = 1'b0;
        if (rst) begin
            ifidFlush     = 1'b1;
            idexBubble    = 1'b1;
            nextState     = RUN;
            pendFlushNext = 1'b0;
        end else begin
            case (curState)
                RUN, MEMWAIT: begin
                    if (memBusy) begin
                        // Everything freezes; a flush arriving now is remembered for the release cycle.
                        nextState = MEMWAIT;
                        if (flushReq)
                            pendFlushNext = 1'b1;
                    end else begin
                        pcEn          = 1'b1;
                        ifidEn        = 1'b1;
                        idexEn        = 1'b1;
                        exmemEn       = 1'b1;
                        memwbEn       = 1'b1;
                        pendFlushNext = 1'b0;
                        nextState     = haltReq ? HALT : RUN;
                        if (flushReq || pendFlush) begin
                            ifidFlush  = 1'b1;
                            idexBubble = 1'b1;
                        end else if (stallReq) begin
                            pcEn       = 1'b0;
                            ifidEn     = 1'b0;
                            idexBubble = 1'b1;
                        end
                    end
                end
                default: begin
                    // HALT and the reserved encoding are sticky until reset.
                    halted = 1'b1;
                end
            endcase
        end
    end

`ifdef PIPE_PERF_EN
    logic countCyc, stallCyc, flushCyc;

    // Outside reset/halt, pcEn is low exactly on hazard-stall or memory-wait cycles.
    assign countCyc = !rst && !halted;
    assign stallCyc = countCyc && !pcEn;
    assign flushCyc = countCyc && ifidFlush;

    always_ff @(posedge clk) begin
        if (rst) begin
            cycCnt   <= 16'd0;
            stallCnt <= 16'd0;
            flushCnt <= 16'd0;
        end else begin
            if (countCyc && cycCnt != 16'hFFFF)
                cycCnt <= cycCnt + 16'd1;
            if (stallCyc && stallCnt != 16'hFFFF)
                stallCnt <= stallCnt + 16'd1;
            if (flushCyc && flushCnt != 16'hFFFF)
                flushCnt <= flushCnt + 16'd1;
        end
    end
`endif

endmodule
